// File: rtl/snn_decay_pkg.sv
// ============================================================================
// Module  : snn_decay_pkg
// Brief   : Shared decay-rate codes, FP32 field widths and sweep FSM states
//           for the membrane-potential decay engines.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_decay_pkg;

  // Per-neuron decay-rate codes
  localparam logic [3:0] DECAY_X1      = 4'b0001;
  localparam logic [3:0] DECAY_HALF    = 4'b0010;
  localparam logic [3:0] DECAY_QUARTER = 4'b0100;
  localparam logic [3:0] DECAY_EIGHTH  = 4'b1000;
  localparam logic [3:0] DECAY_3Q4     = 4'b0011;

  // IEEE-754 single-precision field layout
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int SIG_W  = MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fp32_decay_unit.sv
// ============================================================================
// Module  : fp32_decay_unit
// Brief   : Combinational FP32 multiply by 1, 1/2, 1/4, 1/8 or 3/4 selected by
//           a 4-bit decay code. Truncating, flushes underflow to signed zero,
//           passes Inf/NaN through untouched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_decay_unit
  import snn_decay_pkg::*;
(
  input  logic [31:0] in,
  input  logic [3:0]  rate,
  output logic [31:0] out
);

  logic             sign;
  logic [EXP_W-1:0] exp_in;
  logic [MAN_W-1:0] man_in;
  logic [SIG_W-1:0] sig;
  logic [SIG_W:0]   sum_3q4;
  logic [EXP_W-1:0] shift_k;
  logic [EXP_W-1:0] exp_shift;
  logic [EXP_W-1:0] exp_dec;

  assign sign   = in[31];
  assign exp_in = in[30:23];
  assign man_in = in[22:0];

  // 3/4 of the significand as sig + sig/2, then renormalised below
  assign sig     = {1'b1, man_in};
  assign sum_3q4 = {1'b0, sig} + {2'b00, sig[SIG_W-1:1]};

  assign exp_shift = exp_in - shift_k;
  assign exp_dec   = exp_in - 8'd1;

  // Select the exponent shift for power-of-two codes
  always_comb begin
    shift_k = 8'd0;
    case (rate)
      DECAY_HALF:    shift_k = 8'd1;
      DECAY_QUARTER: shift_k = 8'd2;
      DECAY_EIGHTH:  shift_k = 8'd3;
      default:       shift_k = 8'd0;
    endcase
  end

  // Apply the decay with special-operand and underflow handling
  always_comb begin
    out = in;
    if (exp_in == '0) begin
      out = {sign, 31'b0};
    end else if (exp_in == EXP_MAX) begin
      out = in;
    end else if (rate == DECAY_3Q4) begin
      if (sum_3q4[SIG_W]) begin
        out = {sign, exp_in, sum_3q4[SIG_W-1:1]};
      end else if (exp_in == 8'd1) begin
        out = {sign, 31'b0};
      end else begin
        out = {sign, exp_dec, sum_3q4[MAN_W-1:0]};
      end
    end else if (shift_k != 8'd0) begin
      // Result exponent of zero or below is flushed, never wrapped
      if (exp_in <= shift_k) begin
        out = {sign, 31'b0};
      end else begin
        out = {sign, exp_shift, man_in};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/potential_decay_engine.sv
// ============================================================================
// Module  : potential_decay_engine
// Brief   : Time-multiplexed decay of NUM_NEURONS FP32 membrane potentials.
//           A start pulse sweeps every neuron through one shared decay unit,
//           streams results over valid/ready and writes them back.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module potential_decay_engine
  import snn_decay_pkg::*;
#(
  parameter int          NUM_NEURONS    = 32,
  parameter int          ADDR_W         = $clog2(NUM_NEURONS),
  parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852,
  parameter logic [3:0]  INIT_RATE      = 4'b0001
)(
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pot_we,
  input  logic [ADDR_W-1:0] pot_addr,
  input  logic [31:0]       pot_data,
  output logic              pot_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  logic [31:0]       pot_mem  [NUM_NEURONS];
  logic [3:0]        rate_mem [NUM_NEURONS];

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] next_idx;
  logic [31:0]       rd_pot;
  logic [3:0]        rd_rate;
  logic [31:0]       decayed;
  logic              handshake;
  logic              last_out;
  logic              pot_wr_ok;
  logic              cfg_wr_ok;

  // idx always names the next neuron to be loaded into the output register
  assign rd_pot    = pot_mem[idx];
  assign rd_rate   = rate_mem[idx];
  assign next_idx  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign handshake = out_valid && out_ready;
  assign last_out  = (out_addr == LAST_IDX);
  assign pot_wr_ok = pot_we && pot_ready && (int'(pot_addr) < NUM_NEURONS);
  assign cfg_wr_ok = cfg_we && (int'(cfg_addr) < NUM_NEURONS);

  fp32_decay_unit u_decay (
    .in   (rd_pot),
    .rate (rd_rate),
    .out  (decayed)
  );

  // Sweep controller with registered stream outputs and status flags
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_potential <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pot_ready     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_SWEEP;
            busy          <= 1'b1;
            pot_ready     <= 1'b0;
            out_valid     <= 1'b1;
            out_addr      <= idx;
            out_potential <= decayed;
            idx           <= next_idx;
          end
        end
        ST_SWEEP: begin
          // Output register only advances when the held result is consumed
          if (handshake) begin
            if (last_out) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              idx       <= '0;
            end else begin
              out_addr      <= idx;
              out_potential <= decayed;
              idx           <= next_idx;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          pot_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          pot_ready <= 1'b1;
        end
      endcase
    end
  end

  // Potential array: sweep write-back or adder write, never both at once
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_mem[i] <= INIT_POTENTIAL;
      end
    end else if (handshake) begin
      pot_mem[out_addr] <= out_potential;
    end else if (pot_wr_ok) begin
      pot_mem[pot_addr] <= pot_data;
    end
  end

  // Decay-rate array, writable in any state
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        rate_mem[i] <= INIT_RATE;
      end
    end else if (cfg_wr_ok) begin
      rate_mem[cfg_addr] <= cfg_rate;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_potential_decay_engine.sv
// ============================================================================
// Module  : tb_potential_decay_engine
// Brief   : Scoreboard bench for potential_decay_engine sweeps, boundary
//           operands, backpressure, ignored writes and mid-sweep reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_potential_decay_engine;

  localparam int          N        = 32;
  localparam int          AW       = 5;
  localparam int          CYC_MAX  = 400;
  localparam logic [31:0] INIT_POT = 32'h41DED852;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pot_we = 1'b0;
  logic [AW-1:0] pot_addr = '0;
  logic [31:0]   pot_data = '0;
  logic          pot_ready;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_rate = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_potential;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pot  [N];
  logic [3:0]  m_rate [N];
  logic [31:0] obs    [N];
  int          n_checks = 0;
  int          n_errors = 0;

  potential_decay_engine #(.NUM_NEURONS(N)) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .start         (start),
    .pot_we        (pot_we),
    .pot_addr      (pot_addr),
    .pot_data      (pot_data),
    .pot_ready     (pot_ready),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_rate      (cfg_rate),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_potential (out_potential),
    .busy          (busy),
    .done          (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decay written from the arithmetic definition
  function automatic logic [31:0] ref_decay(input logic [31:0] v, input logic [3:0] r);
    int          e;
    int          sh;
    logic [25:0] t;
    logic [24:0] p;
    e = int'(v[30:23]);
    if (e == 0)   return {v[31], 31'b0};
    if (e == 255) return v;
    case (r)
      4'b0010: sh = 1;
      4'b0100: sh = 2;
      4'b1000: sh = 3;
      4'b0011: sh = -1;
      default: sh = 0;
    endcase
    if (sh == 0) return v;
    if (sh > 0) begin
      if (e - sh <= 0) return {v[31], 31'b0};
      return {v[31], 8'(e - sh), v[22:0]};
    end
    t = 26'({1'b1, v[22:0]}) * 26'd3;
    p = t[25:1];
    if (p[24]) return {v[31], 8'(e), p[23:1]};
    if (e - 1 <= 0) return {v[31], 31'b0};
    return {v[31], 8'(e - 1), p[22:0]};
  endfunction

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      m_pot[i]  = INIT_POT;
      m_rate[i] = 4'b0001;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    model_init();
  endtask

  task automatic write_nrn(input bit dp, input bit dc, input int a,
                           input logic [31:0] d, input logic [3:0] r);
    @(negedge CLK);
    pot_we   = dp;
    cfg_we   = dc;
    pot_addr = AW'(a);
    cfg_addr = AW'(a);
    pot_data = d;
    cfg_rate = r;
    @(negedge CLK);
    pot_we = 1'b0;
    cfg_we = 1'b0;
    if (dp) m_pot[a] = d;
    if (dc) m_rate[a] = r;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1
  // abort_at >= 0: pulse rst_n low while that neuron is presented
  // poke: drop a pot_we and a start into the running sweep
  task automatic run_sweep(input int mode, input int abort_at, input bit poke);
    int            hs;
    int            cyc;
    bit            fin;
    bit            aborted;
    bit            prev_stall;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_pot;
    exp_t          e;
    hs = 0; cyc = 0; fin = 0; aborted = 0; prev_stall = 0;
    h_addr = '0; h_pot = '0;
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < N; i++) begin
      e.a = AW'(i);
      e.d = ref_decay(m_pot[i], m_rate[i]);
      sb.push_back(e);
      m_pot[i] = e.d;
    end
    @(negedge CLK);
    start = 1'b0;
    check("first_valid", 32'(out_valid), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    check("pot_ready_low", 32'(pot_ready), 32'd0);
    while (!fin && cyc < CYC_MAX) begin
      pot_we = 1'b0;
      start  = 1'b0;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_addr", 32'(out_addr), 32'(h_addr));
        check("stall_pot", out_potential, h_pot);
      end
      if (sb.size() == 0) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        check("valid_off", 32'(out_valid), 32'd0);
        fin = 1;
      end else if (abort_at >= 0 && hs == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_pot", out_potential, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pot_ready", 32'(pot_ready), 32'd1);
        sb.delete();
        model_init();
        @(negedge CLK);
        rst_n   = 1'b1;
        aborted = 1;
        fin     = 1;
      end else begin
        out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        if (poke && hs == 3) begin
          pot_we   = 1'b1;
          pot_addr = AW'(20);
          pot_data = 32'h12345678;
          start    = 1'b1;
        end
        check("valid_in_sweep", 32'(out_valid), 32'd1);
        prev_stall = out_valid && !out_ready;
        h_addr     = out_addr;
        h_pot      = out_potential;
        if (out_valid && out_ready) begin
          e = sb.pop_front();
          check("out_addr", 32'(out_addr), 32'(e.a));
          check("out_pot", out_potential, e.d);
          obs[e.a] = out_potential;
          hs++;
        end
      end
      cyc++;
      @(negedge CLK);
    end
    pot_we    = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    check("sweep_finished", 32'(fin), 32'd1);
    if (!aborted) begin
      check("handshakes", 32'(hs), 32'(N));
      @(negedge CLK);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_pot_ready", 32'(pot_ready), 32'd1);
    end
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_init();
    repeat (3) @(negedge CLK);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pot_ready", 32'(pot_ready), 32'd1);
    check("reset_addr", 32'(out_addr), 32'd0);
    check("reset_pot", out_potential, 32'd0);
    rst_n = 1'b1;

    // Halving sweep twice across all neurons
    for (int i = 0; i < N; i++) write_nrn(0, 1, i, 32'd0, 4'b0010);
    run_sweep(0, -1, 0);
    check("half_lit_0", obs[0], 32'h415ED852);
    check("half_lit_31", obs[31], 32'h415ED852);
    run_sweep(0, -1, 0);
    check("half2_lit_17", obs[17], 32'h40DED852);

    // One neuron at 1/8 with potential and rate written in the same cycle
    do_reset();
    write_nrn(1, 1, 5, INIT_POT, 4'b1000);
    run_sweep(0, -1, 0);
    check("eighth_lit_5", obs[5], 32'h405ED852);
    check("x1_lit_4", obs[4], 32'h41DED852);

    // 3/4 arithmetic and boundary operands
    write_nrn(1, 1, 0, 32'h40800000, 4'b0011);
    write_nrn(1, 1, 1, 32'h3FC00000, 4'b0011);
    write_nrn(1, 1, 2, 32'hC0800000, 4'b0011);
    write_nrn(1, 1, 3, 32'h00800000, 4'b0010);
    write_nrn(1, 1, 4, 32'h80800000, 4'b0010);
    write_nrn(1, 1, 5, 32'h7FC00000, 4'b0010);
    write_nrn(1, 1, 6, 32'h00000000, 4'b0010);
    write_nrn(1, 1, 7, INIT_POT,     4'b0101);
    write_nrn(1, 1, 8, 32'h00400000, 4'b0011);
    write_nrn(1, 1, 9, 32'h00FFFFFF, 4'b0011);
    write_nrn(1, 0, 10, 32'h11111111, 4'b0000);
    write_nrn(1, 0, 10, 32'h3F800000, 4'b0000);
    run_sweep(0, -1, 0);
    check("q34_lit_a", obs[0], 32'h40400000);
    check("q34_lit_b", obs[1], 32'h3F900000);
    check("q34_lit_neg", obs[2], 32'hC0400000);
    check("flush_pos", obs[3], 32'h00000000);
    check("flush_neg", obs[4], 32'h80000000);
    check("nan_pass", obs[5], 32'h7FC00000);
    check("zero_pass", obs[6], 32'h00000000);
    check("other_code_x1", obs[7], INIT_POT);
    check("last_write_wins", obs[10], 32'h3F800000);

    // Backpressure with a dropped pot_we and an ignored start inside
    run_sweep(1, -1, 1);
    run_sweep(0, -1, 0);
    check("dropped_write_20", obs[20], INIT_POT);

    // Mid-sweep reset, then a clean sweep of reinitialised state
    run_sweep(0, 10, 0);
    run_sweep(0, -1, 0);
    check("after_abort_lit_0", obs[0], INIT_POT);
    check("after_abort_lit_10", obs[10], INIT_POT);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
